// File: rtl/proc_ctrl_unit.sv
// proc_ctrl_unit: multi-cycle sequencer for the 8-bit accumulator processor.
// Every instruction steps FETCH -> DECODE -> EXECUTE -> WRITEBACK; HLT parks
// the unit in HALT until reset. The datapath strobes are registered and last
// for the EXECUTE cycle only.
// Optional build macro: CTRL_SINGLE_STEP_EN adds a 'step' input. With it,
// WRITEBACK waits for step=1 before it retires the instruction.
module proc_ctrl_unit #(
    parameter int PC_WIDTH = 5,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rstn,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic                run,
    input  logic [15:0]         instr_data,
    input  logic                alu_flag_z,
    input  logic                alu_flag_cy,
    output logic [PC_WIDTH-1:0] pc,
    output logic                rom_oe,
    output logic [3:0]          ir_opcode,
    output logic [7:0]          imm,
    output logic                reg_sel,
    output logic                acu_load,
    output logic [1:0]          acu_src,
    output logic                reg_we,
    output logic                flag_z_q,
    output logic                flag_cy_q,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SRC_IMM = 2'd0;
    localparam logic [1:0] SRC_REG = 2'd1;
    localparam logic [1:0] SRC_ALU = 2'd2;

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

    state_t state;
    logic   wb_go;
    logic   unused_instr_bits;

    // Register-select field is one bit wide; the upper select bits are spare.
    assign unused_instr_bits = ^instr_data[11:9];

`ifdef CTRL_SINGLE_STEP_EN
    assign wb_go = step;
`else
    assign wb_go = 1'b1;
`endif

    // ADD, SUB, AND, OR, XOR: the only opcodes that load from the ALU and update flags.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h4) && (op <= 4'h8);
    endfunction

    // Branch decision uses flags latched by earlier ALU instructions.
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic       fz,
                                          input logic       fcy);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = fz;
            OP_JC:   taken = fcy;
            OP_JNZ:  taken = ~fz;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Instruction sequencer with all control outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_FETCH;
            pc        <= RESET_PC_V;
            ir_opcode <= 4'h0;
            imm       <= 8'h00;
            reg_sel   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_cy_q <= 1'b0;
            acu_load  <= 1'b0;
            acu_src   <= SRC_IMM;
            reg_we    <= 1'b0;
            halted    <= 1'b0;
            rom_oe    <= 1'b1;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            acu_load <= 1'b0;
            reg_we   <= 1'b0;
            case (state)
                S_FETCH: begin
                    rom_oe <= 1'b1;
                    if (run) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ir_opcode <= instr_data[15:12];
                    reg_sel   <= instr_data[8];
                    imm       <= instr_data[7:0];
                    rom_oe    <= 1'b0;
                    state     <= S_EXECUTE;
                    // Strobes are decoded from the ROM word so they are
                    // already valid in the first EXECUTE cycle.
                    acu_src   <= SRC_IMM;
                    if (instr_data[15:12] == OP_LDI) begin
                        acu_load <= 1'b1;
                        acu_src  <= SRC_IMM;
                    end else if (instr_data[15:12] == OP_LDR) begin
                        acu_load <= 1'b1;
                        acu_src  <= SRC_REG;
                    end else if (instr_data[15:12] == OP_STR) begin
                        reg_we   <= 1'b1;
                    end else if (is_alu_op(instr_data[15:12])) begin
                        acu_load <= 1'b1;
                        acu_src  <= SRC_ALU;
                    end
                end
                S_EXECUTE: begin
                    // Flags are captured on the same edge the accumulator loads.
                    if (is_alu_op(ir_opcode)) begin
                        flag_z_q  <= alu_flag_z;
                        flag_cy_q <= alu_flag_cy;
                    end
                    if (ir_opcode == OP_HLT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        rom_oe <= 1'b0;
                    end else begin
                        state  <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_go) begin
                        if (branch_taken(ir_opcode, flag_z_q, flag_cy_q)) begin
                            pc <= PC_WIDTH'(imm);
                        end else begin
                            pc <= pc + PC_WIDTH'(1);
                        end
                        state  <= S_FETCH;
                        rom_oe <= 1'b1;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                    rom_oe <= 1'b0;
                end
                default: begin
                    state  <= S_FETCH;
                    rom_oe <= 1'b1;
                end
            endcase
        end
    end

endmodule
